pipelined_cla_adder: RTL and testbench
======================================

Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined successor to the team's flat 64-bit carry-lookahead adder.
- Splits the operand width into STAGES segments and adds one segment per clock. Each segment uses grouped carry-lookahead logic; the carry between segments is registered.
- Adds subtract mode, carry-in, carry-out, signed overflow and a valid/ready handshake on both sides, so it can sit in the 4-way adder datapath with back-pressure.

Parameters:
- WIDTH, 64, operand/result width in bits. Must be divisible by STAGES.
- STAGES, 4, number of pipeline segments; also the latency in cycles. Range 1..WIDTH.
- BLOCK, 4, CLA group size inside one segment. SEG = WIDTH/STAGES must be divisible by BLOCK.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand beat present
- in_ready  out  1  block accepts a beat this cycle
- sayi1  in  WIDTH  operand A
- sayi2  in  WIDTH  operand B
- cin  in  1  carry-in; ignored when sub=1
- sub  in  1  0: A+B+cin; 1: A-B, computed as A+~B+1
- out_valid  out  1  result beat present
- out_ready  in  1  downstream accepts the result
- toplam  out  WIDTH  sum/difference
- cout  out  1  carry out of the MSB (for sub: 1 = no borrow)
- ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Clock and reset: one clock domain. rst_n is asynchronous, active-low. Deassertion is synchronised externally.
- Reset state:
  - every stage valid bit = 0 and every data register = 0, so toplam=0, cout=0, ovf=0, out_valid=0;
  - in_ready=0 while rst_n=0.
- Stage contents: stage k (0..STAGES-1) holds:
  - a valid bit;
  - the completed low sum bits [k*SEG+SEG-1:0];
  - the registered carry out of segment k;
  - the still-unprocessed upper operand bits (B already inverted if sub);
  - the ovf flag (last stage only).
- Stage 0 logic: adds segment 0 of sayi1 and (sub ? ~sayi2 : sayi2) with carry-in (sub ? 1 : cin).
- Stage k>0 logic: adds segment k of the skewed operands using the registered carry from stage k-1.
- Segment adder: within a segment, generate/propagate per bit, group G/P per BLOCK bits, and group carries computed by lookahead. No ripple across groups.
- Global advance enable: en = out_ready | ~out_valid.
  - in_ready = en (combinational, 0 during reset).
  - When en=1, every stage loads from its predecessor, and stage 0 loads {in_valid, ...}.
  - When en=0, all stages hold.
  - Bubbles are not collapsed; a bubble advances as a valid=0 beat.
- Latency: a beat accepted at edge t (in_valid & in_ready) presents out_valid=1 after edge t+STAGES-1, provided en stays 1. Throughput is 1 beat/cycle.
- Output stability: while out_valid=1 and out_ready=0, toplam/cout/ovf/out_valid are held stable.
- Simultaneous events: the last stage may drain while stage 0 accepts in the same cycle. Outputs keep strict in-order delivery.
- Output registers: toplam, cout and ovf come straight from last-stage registers with no combinational path from inputs. in_ready is combinational from out_ready.
- Wrap-around: results are modulo 2^WIDTH; the carry appears only on cout.
- Reset mid-operation: all in-flight beats are discarded immediately, out_valid drops asynchronously, and no result from those beats ever appears.
- STAGES=1: the block is a single registered CLA with latency 1.
- Elaboration error: raised if WIDTH%STAGES != 0 or SEG%BLOCK != 0.

Decomposition:
- Shared package cla_pkg:
  - default WIDTH/STAGES/BLOCK constants;
  - helper function seg_w(WIDTH,STAGES);
  - stage-record field-width localparams.
- One combinational sub-module, cla_segment (parameter SEG, BLOCK):
  - inputs a, b, ci;
  - outputs s, co, c_msb (carry into the segment MSB, used for ovf).
- The top instantiates STAGES copies of cla_segment plus the pipeline registers.

Test Plan (WIDTH=64, STAGES=4):
- Reset: hold rst_n=0 with random inputs -> out_valid=0, toplam=0, cout=0, ovf=0, in_ready=0; release -> in_ready=1.
- Carry chain: sayi1=0xFFFF_FFFF_FFFF_FFFF, sayi2=1, sub=0, cin=0 -> after 4 cycles toplam=0, cout=1, ovf=0.
- Subtract: sayi1=5, sayi2=7, sub=1 -> toplam=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0. Then sayi1=7, sayi2=5 -> toplam=2, cout=1.
- Signed overflow: sayi1=0x7FFF_FFFF_FFFF_FFFF, sayi2=1 -> toplam=0x8000_0000_0000_0000, ovf=1, cout=0. Also cin=1 with 0+0 -> toplam=1.
- Back-pressure: stream 10 random beats and hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 while the last stage is full, outputs stable, all 10 results correct and in order, none lost or duplicated.
- Reset mid-flight: 3 beats in flight, pulse rst_n low for half a cycle -> out_valid falls immediately, and none of the 3 results emerge afterwards.

Source files
------------

// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cla_pkg
// Brief    : Shared defaults and sizing helpers for the pipelined CLA adder.
// Revision : 1.0 - initial release
// ============================================================================
package cla_pkg;

    localparam int unsigned c_def_width  = 64;
    localparam int unsigned c_def_stages = 4;
    localparam int unsigned c_def_block  = 4;

    // Width of the single-bit stage-record fields (valid, carry, ovf).
    localparam int unsigned c_flag_w     = 1;

    function automatic int unsigned seg_w(input int unsigned width, input int unsigned stages);
        return width / stages;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla_segment.sv
`default_nettype none
// ============================================================================
// Module   : cla_segment
// Brief    : Combinational grouped carry-lookahead adder for one segment.
// Revision : 1.0 - initial release
// ============================================================================
module cla_segment #(
    parameter int unsigned SEG   = 16,
    parameter int unsigned BLOCK = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co,
    output logic           c_msb
);

    localparam int unsigned c_ngrp = SEG / BLOCK;

    if ((SEG % BLOCK) != 0) begin : g_param_check
        $error("cla_segment: SEG must be a multiple of BLOCK");
    end

    logic [SEG-1:0]    w_gen;
    logic [SEG-1:0]    w_prop;
    logic [SEG-1:0]    w_carry;
    logic [c_ngrp-1:0] w_grp_g;
    logic [c_ngrp-1:0] w_grp_p;
    logic [c_ngrp:0]   w_grp_c;

    assign w_gen  = a & b;
    assign w_prop = a ^ b;

    always_comb begin : p_group_gp
        logic w_term;
        logic w_acc;
        for (int j = 0; j < c_ngrp; j++) begin
            w_grp_p[j] = &w_prop[j*BLOCK +: BLOCK];
            w_acc = 1'b0;
            for (int i = 0; i < BLOCK; i++) begin
                w_term = w_gen[j*BLOCK+i];
                for (int m = i + 1; m < BLOCK; m++) begin
                    w_term = w_term & w_prop[j*BLOCK+m];
                end
                w_acc = w_acc | w_term;
            end
            w_grp_g[j] = w_acc;
        end
    end

    // Every group carry is a flat sum of products of group G/P and ci.
    always_comb begin : p_group_carry
        logic w_term;
        logic w_acc;
        for (int j = 0; j <= c_ngrp; j++) begin
            w_term = ci;
            for (int i = 0; i < j; i++) begin
                w_term = w_term & w_grp_p[i];
            end
            w_acc = w_term;
            for (int i = 0; i < j; i++) begin
                w_term = w_grp_g[i];
                for (int m = i + 1; m < j; m++) begin
                    w_term = w_term & w_grp_p[m];
                end
                w_acc = w_acc | w_term;
            end
            w_grp_c[j] = w_acc;
        end
    end

    always_comb begin : p_bit_carry
        logic w_term;
        logic w_acc;
        for (int j = 0; j < c_ngrp; j++) begin
            for (int i = 0; i < BLOCK; i++) begin
                w_term = w_grp_c[j];
                for (int m = 0; m < i; m++) begin
                    w_term = w_term & w_prop[j*BLOCK+m];
                end
                w_acc = w_term;
                for (int k = 0; k < i; k++) begin
                    w_term = w_gen[j*BLOCK+k];
                    for (int m = k + 1; m < i; m++) begin
                        w_term = w_term & w_prop[j*BLOCK+m];
                    end
                    w_acc = w_acc | w_term;
                end
                w_carry[j*BLOCK+i] = w_acc;
            end
        end
    end

    assign s     = w_prop ^ w_carry;
    assign co    = w_grp_c[c_ngrp];
    assign c_msb = w_carry[SEG-1];

endmodule
`default_nettype wire

// File: rtl/pipelined_cla_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_cla_adder
// Brief    : STAGES-deep pipelined CLA add/subtract with valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH  = c_def_width,
    parameter int unsigned STAGES = c_def_stages,
    parameter int unsigned BLOCK  = c_def_block
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sayi1,
    input  logic [WIDTH-1:0] sayi2,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] toplam,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned c_seg  = seg_w(WIDTH, STAGES);
    localparam int unsigned c_nops = (STAGES > 1) ? STAGES - 1 : 1;

    if (((WIDTH % STAGES) != 0) || ((c_seg % BLOCK) != 0)) begin : g_param_check
        $error("pipelined_cla_adder: WIDTH%%STAGES and SEG%%BLOCK must both be zero");
    end

    // Stage k keeps the finished low sum, its carry, and the operands still to be added.
    logic [STAGES-1:0]   r_valid;
    logic [WIDTH-1:0]    r_sum   [STAGES];
    logic                r_carry [STAGES];
    logic [WIDTH-1:0]    r_op_a  [c_nops];
    logic [WIDTH-1:0]    r_op_b  [c_nops];
    logic [c_flag_w-1:0] r_ovf;

    logic             w_en;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;
    logic [c_seg-1:0] w_seg_a  [STAGES];
    logic [c_seg-1:0] w_seg_b  [STAGES];
    logic [c_seg-1:0] w_seg_s  [STAGES];
    logic             w_seg_ci [STAGES];
    logic             w_seg_co [STAGES];
    logic             w_seg_cm [STAGES];
    logic [WIDTH-1:0] w_sum_nxt [STAGES];

    assign w_en      = out_ready | ~r_valid[STAGES-1];
    assign in_ready  = rst_n & w_en;
    assign w_b_eff   = sub ? ~sayi2 : sayi2;
    assign w_cin_eff = sub | cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign w_seg_a[k]  = sayi1[c_seg-1:0];
            assign w_seg_b[k]  = w_b_eff[c_seg-1:0];
            assign w_seg_ci[k] = w_cin_eff;
        end else begin : g_next
            assign w_seg_a[k]  = r_op_a[k-1][k*c_seg +: c_seg];
            assign w_seg_b[k]  = r_op_b[k-1][k*c_seg +: c_seg];
            assign w_seg_ci[k] = r_carry[k-1];
        end

        cla_segment #(
            .SEG   (c_seg),
            .BLOCK (BLOCK)
        ) u_seg (
            .a     (w_seg_a[k]),
            .b     (w_seg_b[k]),
            .ci    (w_seg_ci[k]),
            .s     (w_seg_s[k]),
            .co    (w_seg_co[k]),
            .c_msb (w_seg_cm[k])
        );
    end

    always_comb begin
        w_sum_nxt[0]            = '0;
        w_sum_nxt[0][c_seg-1:0] = w_seg_s[0];
        for (int k = 1; k < STAGES; k++) begin
            w_sum_nxt[k]                    = r_sum[k-1];
            w_sum_nxt[k][k*c_seg +: c_seg]  = w_seg_s[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_ovf   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_sum[k]   <= '0;
                r_carry[k] <= 1'b0;
            end
            for (int k = 0; k < c_nops; k++) begin
                r_op_a[k] <= '0;
                r_op_b[k] <= '0;
            end
        end else if (w_en) begin
            // Whole pipeline shifts together; empty slots travel as valid=0 beats.
            r_valid[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                r_valid[k] <= r_valid[k-1];
            end
            for (int k = 0; k < STAGES; k++) begin
                r_sum[k]   <= w_sum_nxt[k];
                r_carry[k] <= w_seg_co[k];
            end
            r_op_a[0] <= sayi1;
            r_op_b[0] <= w_b_eff;
            for (int k = 1; k < c_nops; k++) begin
                r_op_a[k] <= r_op_a[k-1];
                r_op_b[k] <= r_op_b[k-1];
            end
            r_ovf <= w_seg_cm[STAGES-1] ^ w_seg_co[STAGES-1];
        end
    end

    assign out_valid = r_valid[STAGES-1];
    assign toplam    = r_sum[STAGES-1];
    assign cout      = r_carry[STAGES-1];
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_cla_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_cla_adder
// Brief    : Self-checking bench for pipelined_cla_adder (WIDTH=64, STAGES=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_cla_adder;

    localparam int W  = 64;
    localparam int ST = 4;
    localparam logic signed [W+1:0] c_smax = $signed({3'b000, {(W-1){1'b1}}});
    localparam logic signed [W+1:0] c_smin = -c_smax - 1;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } res_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] sayi1;
    logic [W-1:0] sayi2;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] toplam;
    logic         cout;
    logic         ovf;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pipelined_cla_adder #(
        .WIDTH  (W),
        .STAGES (ST),
        .BLOCK  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sayi1     (sayi1),
        .sayi2     (sayi2),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .toplam    (toplam),
        .cout      (cout),
        .ovf       (ovf)
    );

    int   total;
    int   bad;
    int   n_in;
    int   n_out;
    res_t q[$];
    res_t last_out;
    res_t hold_r;
    logic hold_v;

    // Reference: plain wide arithmetic, signed overflow from the exact signed result.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci, input logic sb);
        res_t                r;
        logic signed [W+1:0] sa;
        logic signed [W+1:0] sbv;
        logic signed [W+1:0] t;
        logic [W:0]          u;
        sa  = $signed({{2{a[W-1]}}, a});
        sbv = $signed({{2{b[W-1]}}, b});
        if (sb) begin
            u   = {1'b0, a} - {1'b0, b};
            r.c = (a >= b);
            t   = sa - sbv;
        end else begin
            u   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
            r.c = u[W];
            t   = sa + sbv + $signed({{(W+1){1'b0}}, ci});
        end
        r.s = u[W-1:0];
        r.o = (t > c_smax) || (t < c_smin);
        return r;
    endfunction

    function automatic logic [W-1:0] rand_op();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = '1;
            1:       v = '0;
            2:       v = {1'b1, {(W-1){1'b0}}};
            3:       v = {1'b0, {(W-1){1'b1}}};
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, score handshakes, return just after the rising edge.
    task automatic cycle();
        res_t e;
        @(negedge clk);
        chk("in_ready_rule", in_ready, rst_n && (out_ready || !out_valid));
        if (hold_v) begin
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_toplam", toplam, hold_r.s);
            chk("stall_cout", cout, hold_r.c);
            chk("stall_ovf", ovf, hold_r.o);
        end
        hold_v = out_valid && !out_ready;
        hold_r = '{s: toplam, c: cout, o: ovf};
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("spurious_out_valid", out_valid, 1'b0);
            end else begin
                e = q.pop_front();
                chk("toplam", toplam, e.s);
                chk("cout", cout, e.c);
                chk("ovf", ovf, e.o);
            end
            last_out = '{s: toplam, c: cout, o: ovf};
            n_out++;
        end
        if (in_valid && in_ready) begin
            q.push_back(model(sayi1, sayi2, cin, sub));
            n_in++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int lim);
        int c;
        c = 0;
        while (q.size() > 0 && c < lim) begin
            cycle();
            c++;
        end
        chk("drain_timeout", q.size(), 0);
    endtask

    task automatic run_one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic ci, input logic sb,
                           input logic [W-1:0] es, input logic ec, input logic eo);
        int m;
        out_ready = 1'b1;
        sayi1 = a; sayi2 = b; cin = ci; sub = sb; in_valid = 1'b1;
        m = n_in;
        cycle();
        chk({tag, "_accept"}, n_in, m + 1);
        in_valid = 1'b0;
        sayi1 = rand_op(); sayi2 = rand_op(); cin = 1'($urandom); sub = 1'($urandom);
        m = n_out;
        repeat (ST - 1) cycle();
        chk({tag, "_early"}, n_out, m);
        cycle();
        chk({tag, "_latency"}, n_out, m + 1);
        chk({tag, "_toplam"}, last_out.s, es);
        chk({tag, "_cout"}, last_out.c, ec);
        chk({tag, "_ovf"}, last_out.o, eo);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int m;
        int got;
        int base;
        int c;
        total = 0; bad = 0; n_in = 0; n_out = 0; hold_v = 1'b0;
        last_out = '0; hold_r = '0;
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        cin = 1'b0; sub = 1'b0; sayi1 = '0; sayi2 = '0;
        #1 rst_n = 1'b0;

        // Reset held with random stimulus
        repeat (4) begin
            in_valid = 1'($urandom); out_ready = 1'($urandom);
            sayi1 = rand_op(); sayi2 = rand_op(); cin = 1'($urandom); sub = 1'($urandom);
            cycle();
        end
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_toplam", toplam, '0);
        chk("rst_cout", cout, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        in_valid = 1'b0; out_ready = 1'b0;
        rst_n = 1'b1;
        #1 chk("rst_release_in_ready", in_ready, 1'b1);

        // Directed corner cases
        run_one("carry_chain", '1, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
        run_one("sub_5_7", 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        run_one("sub_7_5", 64'd7, 64'd5, 1'b1, 1'b1, 64'd2, 1'b1, 1'b0);
        run_one("signed_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                64'h8000_0000_0000_0000, 1'b0, 1'b1);
        run_one("cin_only", 64'd0, 64'd0, 1'b1, 1'b0, 64'd1, 1'b0, 1'b0);

        // Back-pressure: 10 beats with a 3-cycle output stall mid-stream
        base = n_out; got = 0; c = 0;
        sayi1 = rand_op(); sayi2 = rand_op(); cin = 1'($urandom); sub = 1'($urandom);
        in_valid = 1'b1;
        while (got < 10 && c < 60) begin
            out_ready = !(c >= 5 && c < 8);
            m = n_in;
            cycle();
            if (c == 6) chk("bp_in_ready_stalled", in_ready, 1'b0);
            if (n_in != m) begin
                got++;
                sayi1 = rand_op(); sayi2 = rand_op(); cin = 1'($urandom); sub = 1'($urandom);
            end
            c++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp_all_accepted", got, 10);
        drain(60);
        chk("bp_all_out", n_out - base, 10);

        // Random traffic with random back-pressure
        for (int i = 0; i < 80; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            sayi1 = rand_op(); sayi2 = rand_op(); cin = 1'($urandom); sub = 1'($urandom);
            cycle();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        drain(60);

        // Reset with three beats in flight
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            sayi1 = rand_op(); sayi2 = rand_op(); cin = 1'($urandom); sub = 1'($urandom);
            cycle();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        cycle();
        chk("mid_valid_before_rst", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_valid_drop", out_valid, 1'b0);
        chk("mid_toplam_cleared", toplam, '0);
        chk("mid_in_ready_rst", in_ready, 1'b0);
        q.delete();
        hold_v = 1'b0;
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        m = n_out;
        repeat (8) cycle();
        chk("mid_no_results", n_out, m);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
